// File: rtl/sck_edge_tick_recovery_pkg.sv
// Shared definitions for the SPI-side tick recovery and readout FSMs.
// Holds the link state encoding and a width helper that never returns zero.
package sck_edge_tick_recovery_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StActive = 2'd1,
      StError  = 2'd2
   } link_state_e;

   function automatic int unsigned clog2_min1(input int unsigned value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser with registered copy for rise/fall detection.
// Edges are reported only once the compared sample came from the pin, not from reset.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain_q;
   logic                   prev_q;
   logic [SYNC_STAGES:0]   fill_q;
   logic                   level;
   logic                   primed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_q <= {SYNC_STAGES{RESET_LEVEL}};
         prev_q  <= RESET_LEVEL;
         fill_q  <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], din};
         prev_q  <= chain_q[SYNC_STAGES-1];
         fill_q  <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // prev_q holds a real pin sample only after SYNC_STAGES+1 clocks out of reset;
   // this keeps a CS_n held low through reset from looking like a falling edge.
   assign primed = fill_q[SYNC_STAGES];
   assign level  = chain_q[SYNC_STAGES-1];
   assign rise   = primed & level & ~prev_q;
   assign fall   = primed & ~level & prev_q;

endmodule

// File: rtl/sck_edge_tick_recovery.sv
// Recovers SCK edge pulses and a programmable per-word tick from raw SPI pins,
// with a stall watchdog that parks the link in ERROR until the frame ends.
module sck_edge_tick_recovery
   import sck_edge_tick_recovery_pkg::*;
#(
   parameter int unsigned  SYNC_STAGES    = 2,
   parameter int unsigned  BITS_PER_WORD  = 16,
   parameter int unsigned  TICK_EDGE      = 3,
   parameter int unsigned  TIMEOUT_CYCLES = 1000,
   localparam int unsigned CW             = clog2_min1(BITS_PER_WORD)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          spi_sck_in,
   input  logic          spi_cs_n_in,
   output logic          sck_rise,
   output logic          sck_fall,
   output logic          word_tick,
   output logic [CW-1:0] edge_count,
   output logic          active,
   output logic          timeout_err
);

   localparam int unsigned   WW       = clog2_min1(TIMEOUT_CYCLES + 1);
   localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(BITS_PER_WORD - 1);

   logic sck_rise_det, sck_fall_det, cs_rise_det, cs_fall_det;

   link_state_e   state_q, state_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_q, rise_d, fall_q, fall_d, tick_q, tick_d;
   logic          active_q, err_q;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (1'b0)
   ) u_sck_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_sck_in),
      .rise (sck_rise_det),
      .fall (sck_fall_det)
   );

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (1'b1)
   ) u_cs_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_cs_n_in),
      .rise (cs_rise_det),
      .fall (cs_fall_det)
   );

   always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      tick_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            wd_d = '0;
            if (cs_fall_det) state_d = StActive;
         end
         StActive: begin
            // Deselect wins over any SCK edge landing in the same cycle.
            if (cs_rise_det) begin
               state_d = StIdle;
            end else begin
               rise_d = sck_rise_det;
               fall_d = sck_fall_det;
               tick_d = sck_fall_det && (32'(cnt_q) == TICK_EDGE);
               if (sck_rise_det || sck_fall_det) begin
                  wd_d = '0;
               end else if (wd_q != WD_LIMIT) begin
                  wd_d = wd_q + 1'b1;
               end
               if (wd_d == WD_LIMIT) state_d = StError;
            end
         end
         StError: begin
            if (cs_rise_det) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // The count advances the cycle after the sck_fall pulse, so the tick compare
   // always sees the pre-increment value (falls are >= 4 clocks apart).
   always_comb begin
      cnt_d = cnt_q;
      if (state_d == StIdle) begin
         cnt_d = '0;
      end else if (state_q == StActive && fall_q) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         wd_q     <= '0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         tick_q   <= 1'b0;
         active_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wd_q     <= wd_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         tick_q   <= tick_d;
         active_q <= (state_d == StActive);
         err_q    <= (state_d == StError);
      end
   end

   assign sck_rise    = rise_q;
   assign sck_fall    = fall_q;
   assign word_tick   = tick_q;
   assign edge_count  = cnt_q;
   assign active      = active_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_sck_edge_tick_recovery.sv
// Bench: two configurations share the SPI pins; a pin-history reference model
// checks every cycle, plus a frame table and directed corner-case sequences.
module tb_sck_edge_tick_recovery;

   localparam int S1 = 2, BPW1 = 16, TE1 = 3, TO1 = 50;
   localparam int S2 = 3, BPW2 = 4, TE2 = 7, TO2 = 1000;
   localparam int MAXC = 65536;

   logic clk = 1'b0;
   logic rst;
   logic spi_sck, spi_cs_n;
   logic r1, f1, t1, a1, e1;
   logic [3:0] c1;
   logic r2, f2, t2, a2, e2;
   logic [1:0] c2;

   always #5 clk = ~clk;

   sck_edge_tick_recovery #(
      .SYNC_STAGES(S1), .BITS_PER_WORD(BPW1), .TICK_EDGE(TE1), .TIMEOUT_CYCLES(TO1)
   ) dut1 (
      .clk(clk), .rst(rst), .spi_sck_in(spi_sck), .spi_cs_n_in(spi_cs_n),
      .sck_rise(r1), .sck_fall(f1), .word_tick(t1), .edge_count(c1),
      .active(a1), .timeout_err(e1)
   );

   sck_edge_tick_recovery #(
      .SYNC_STAGES(S2), .BITS_PER_WORD(BPW2), .TICK_EDGE(TE2), .TIMEOUT_CYCLES(TO2)
   ) dut2 (
      .clk(clk), .rst(rst), .spi_sck_in(spi_sck), .spi_cs_n_in(spi_cs_n),
      .sck_rise(r2), .sck_fall(f2), .word_tick(t2), .edge_count(c2),
      .active(a2), .timeout_err(e2)
   );

   int n_checks = 0, n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model over sampled pin history ----------------
   bit sck_h[MAXC];
   bit cs_h[MAXC];
   int n = 0, cyc = 0;

   typedef struct {
      int mode;       // 0 idle, 1 in frame, 2 stalled
      int falls;      // falling edges counted in this frame
      int last_evt;   // sample index of last SCK edge or frame entry
      bit rise, fall, tick;
      int cnt;
   } mdl_t;

   mdl_t m1, m2;
   mdl_t m_reset = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 0};

   function automatic bit samp_sck(input int k);
      return (k < 1 || k >= MAXC) ? 1'b0 : sck_h[k];
   endfunction

   function automatic bit samp_cs(input int k);
      return (k < 1 || k >= MAXC) ? 1'b1 : cs_h[k];
   endfunction

   // Outputs after clock n reflect the pin change between samples n-s-1 and n-s;
   // a change only counts when the older sample was taken after reset.
   function automatic mdl_t step(input mdl_t mi, input int k, input int s, input int bpw,
                                 input int te, input int to);
      mdl_t m = mi;
      int a = k - s - 1;
      int b = k - s;
      bit ok = (a >= 1);
      bit cs_f = ok && samp_cs(a) && !samp_cs(b);
      bit cs_r = ok && !samp_cs(a) && samp_cs(b);
      bit sk_r = ok && !samp_sck(a) && samp_sck(b);
      bit sk_f = ok && samp_sck(a) && !samp_sck(b);
      m.rise = 0; m.fall = 0; m.tick = 0;
      case (m.mode)
         0: if (cs_f) begin m.mode = 1; m.falls = 0; m.last_evt = k; end
         1: if (cs_r) m.mode = 0;
            else begin
               m.rise = sk_r;
               m.fall = sk_f;
               m.tick = sk_f && ((m.falls % bpw) == te);
               if (sk_r || sk_f) m.last_evt = k;
               else if (k - m.last_evt >= to) m.mode = 2;
            end
         default: if (cs_r) m.mode = 0;
      endcase
      m.cnt = (m.mode == 0) ? 0 : (m.falls % bpw);
      if (m.fall) m.falls++;
      return m;
   endfunction

   function automatic logic [31:0] pack_m(input mdl_t m);
      return {19'd0, m.mode == 1, m.mode == 2, m.rise, m.fall, m.tick, 8'(m.cnt)};
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         n = 0; m1 = m_reset; m2 = m_reset;
      end else begin
         n++;
         if (n < MAXC) begin sck_h[n] = spi_sck; cs_h[n] = spi_cs_n; end
         m1 = step(m1, n, S1, BPW1, TE1, TO1);
         m2 = step(m2, n, S2, BPW2, TE2, TO2);
      end
   end

   // ---------------- monitor ----------------
   int fall_cnt1 = 0, rise_cnt1 = 0, tick_cnt1 = 0, tick_cnt2 = 0;
   int last_fall_cyc = 0, err_rise_cyc = 0;
   logic err_prev = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (f1) begin fall_cnt1++; last_fall_cyc = cyc; end
         if (r1) rise_cnt1++;
         if (t1) tick_cnt1++;
         if (t2) tick_cnt2++;
         if (e1 && !err_prev) err_rise_cyc = cyc;
         chk("model_cfg1", {19'd0, a1, e1, r1, f1, t1, 8'(c1)}, pack_m(m1));
         chk("model_cfg2", {19'd0, a2, e2, r2, f2, t2, 8'(c2)}, pack_m(m2));
      end
      err_prev = e1;
   end

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic sck_cycles(input int num, input int half);
      for (int i = 0; i < num; i++) begin
         spi_sck = 1'b1; tick(half);
         spi_sck = 1'b0; tick(half);
      end
   endtask

   typedef struct {
      int nsck;
      int exp_falls;
      int exp_ticks;
      int exp_cnt;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k, k1, k2, snap_f, snap_r;
      vecs[0] = '{16, 16, 1, 0};
      vecs[1] = '{40, 40, 3, 8};
      vecs[2] = '{4, 4, 1, 4};
      vecs[3] = '{3, 3, 0, 3};
      vecs[4] = '{20, 20, 2, 4};

      spi_sck = 1'b0; spi_cs_n = 1'b1; rst = 1'b1;
      tick(3);
      chk("reset_state", {20'd0, r1, f1, t1, c1, a1, e1, r2, f2, t2, c2, a2, e2}, 32'd0);
      rst = 1'b0;
      tick(6);

      // Frame table at clk/8
      for (int v = 0; v < 5; v++) begin
         spi_cs_n = 1'b0;
         fall_cnt1 = 0; tick_cnt1 = 0;
         tick(4);
         sck_cycles(vecs[v].nsck, 4);
         tick(8);
         chk("table_falls", fall_cnt1, vecs[v].exp_falls);
         chk("table_ticks", tick_cnt1, vecs[v].exp_ticks);
         chk("table_count", 32'(c1), vecs[v].exp_cnt);
         spi_cs_n = 1'b1;
         tick(8);
      end

      // Pin-to-pulse latency for both synchroniser depths
      spi_cs_n = 1'b0; tick(6);
      spi_sck = 1'b1;
      k = 0; k1 = -1; k2 = -1;
      while ((k1 < 0 || k2 < 0) && k < 12) begin
         @(posedge clk); #1; k++;
         if (r1 && k1 < 0) k1 = k;
         if (r2 && k2 < 0) k2 = k;
      end
      chk("latency_s2", k1, 3);
      chk("latency_s3", k2, 4);
      spi_sck = 1'b0; tick(6);
      spi_cs_n = 1'b1; tick(8);

      // Deselect coincident with the 4th falling edge
      spi_cs_n = 1'b0;
      fall_cnt1 = 0; tick_cnt1 = 0;
      tick(4);
      sck_cycles(3, 4);
      spi_sck = 1'b1; tick(4);
      spi_sck = 1'b0; spi_cs_n = 1'b1;
      tick(8);
      chk("deselect_no_tick", tick_cnt1, 0);
      chk("deselect_falls", fall_cnt1, 3);
      chk("deselect_inactive", a1, 1'b0);
      chk("deselect_count", 32'(c1), 0);

      // Stall watchdog
      spi_cs_n = 1'b0; tick(4);
      sck_cycles(5, 4);
      tick(70);
      chk("timeout_flag", e1, 1'b1);
      chk("timeout_delay", err_rise_cyc - last_fall_cyc, TO1);
      snap_f = fall_cnt1; snap_r = rise_cnt1;
      sck_cycles(3, 4);
      tick(6);
      chk("error_no_fall", fall_cnt1, snap_f);
      chk("error_no_rise", rise_cnt1, snap_r);
      chk("error_count_held", 32'(c1), 5);
      spi_cs_n = 1'b1;
      k = 0;
      while (e1 && k < 10) begin @(posedge clk); #1; k++; end
      chk("error_clear_latency", k, 3);
      tick(8);

      // Reset mid-frame with CS_n held low
      spi_cs_n = 1'b0; tick(4);
      sck_cycles(2, 4);
      rst = 1'b1; #1;
      chk("rst_async_clear", {20'd0, r1, f1, t1, c1, a1, e1, r2, f2, t2, c2, a2, e2}, 32'd0);
      tick(2);
      rst = 1'b0;
      snap_f = fall_cnt1; snap_r = rise_cnt1;
      sck_cycles(6, 4);
      tick(4);
      chk("rst_no_fall", fall_cnt1, snap_f);
      chk("rst_no_rise", rise_cnt1, snap_r);
      chk("rst_not_active", a1, 1'b0);
      spi_cs_n = 1'b1; tick(6);
      spi_cs_n = 1'b0; tick(6);
      chk("rst_reenter", a1, 1'b1);
      spi_cs_n = 1'b1; tick(8);

      // Randomised frames against the model
      for (int fr = 0; fr < 30; fr++) begin
         int d, nsck, half;
         d = $urandom_range(0, 6);
         nsck = $urandom_range(0, 40);
         half = $urandom_range(2, 6);
         spi_cs_n = 1'b0;
         if (d > 0) tick(d);
         for (int i = 0; i < nsck; i++) begin
            spi_sck = 1'b1; tick(half);
            spi_sck = 1'b0;
            if (i == nsck - 1 && $urandom_range(0, 2) == 0) spi_cs_n = 1'b1;
            tick(half);
            if ($urandom_range(0, 15) == 0) tick($urandom_range(30, 70));
         end
         spi_cs_n = 1'b1;
         tick($urandom_range(4, 10));
      end

      chk("cfg2_tick_never", tick_cnt2, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
